// File: rtl/data_mem_responder.sv
// Multi-channel data-memory responder: round-robin arbitration into one single-port RAM with fixed-latency valid/ready acks.
// Optional statistics counters are enabled by defining DATA_MEM_RESPONDER_STATS_EN.
module data_mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int LATENCY       = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    input  logic                                 init_write_enable,
    input  logic [ADDR_BITS-1:0]                 init_address,
    input  logic [DATA_BITS-1:0]                 init_data,
    output logic                                 busy,
    output logic [15:0]                          read_count,
    output logic [15:0]                          write_count
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    state_t                                 state_q [NUM_CONSUMERS];
    state_t                                 state_d [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0][2:0]          cnt_q, cnt_d;
    logic [NUM_CONSUMERS-1:0]               is_write_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q;
    logic [NUM_CONSUMERS-1:0]               ack_enter;
    logic [PTR_W-1:0]                       rr_ptr_q;

    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_write;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [DATA_BITS-1:0] grant_wdata;

    // Round-robin search starting at the pointer; init writes and reset block all grants.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!reset && !init_write_enable) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                idx = (int'(rr_ptr_q) + i) % NUM_CONSUMERS;
                if (!grant_valid && state_q[idx] == S_IDLE &&
                    (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'(idx);
                end
            end
        end
        // Read wins when a channel raises both valids.
        grant_write = !consumer_read_valid[grant_idx];
        grant_addr  = grant_write ? consumer_write_address[grant_idx*ADDR_BITS +: ADDR_BITS]
                                  : consumer_read_address[grant_idx*ADDR_BITS +: ADDR_BITS];
        grant_wdata = consumer_write_data[grant_idx*DATA_BITS +: DATA_BITS];
    end

    always_comb begin
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            ack_enter[c] = 1'b0;
            case (state_q[c])
                S_IDLE: begin
                    if (grant_valid && grant_idx == PTR_W'(c)) begin
                        state_d[c] = S_WAIT;
                        cnt_d[c]   = 3'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q[c] == 3'd0) begin
                        state_d[c]   = S_ACK;
                        ack_enter[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] - 3'd1;
                    end
                end
                S_ACK: begin
                    if (!(is_write_q[c] ? consumer_write_valid[c] : consumer_read_valid[c]))
                        state_d[c] = S_IDLE;
                end
                default: state_d[c] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            consumer_read_ready[c]  = (state_q[c] == S_ACK) && !is_write_q[c];
            consumer_write_ready[c] = (state_q[c] == S_ACK) &&  is_write_q[c];
            busy                    = busy || (state_q[c] != S_IDLE);
        end
    end

    assign consumer_read_data = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            is_write_q <= '0;
            data_q     <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) state_q[c] <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            cnt_q <= cnt_d;
            for (int c = 0; c < NUM_CONSUMERS; c++) state_q[c] <= state_d[c];
            if (grant_valid) begin
                is_write_q[grant_idx] <= grant_write;
                if (!grant_write) data_q[grant_idx] <= mem[grant_addr];
                rr_ptr_q <= (grant_idx == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : PTR_W'(grant_idx + 1'b1);
            end
        end
    end

    // NOTE: the RAM array is deliberately not reset; contents survive reset and are preloaded by the host.
    always_ff @(posedge clk) begin
        if (init_write_enable)
            mem[init_address] <= init_data;
        else if (grant_valid && grant_write)
            mem[grant_addr] <= grant_wdata;
    end

`ifdef DATA_MEM_RESPONDER_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;
    logic        rd_done, wr_done;

    // Latency is fixed and grants are one per edge, so at most one channel enters ACK per edge.
    assign rd_done = |(ack_enter & ~is_write_q);
    assign wr_done = |(ack_enter &  is_write_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_done && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (wr_done && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`else
    assign read_count  = 16'h0000;
    assign write_count = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued at request time and matched on each ready rise.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_valid, rd_ready, wr_valid, wr_ready;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
    logic        init_we;
    logic [7:0]  init_addr, init_dat;
    logic        busy;
    logic [15:0] read_count, write_count;

    typedef struct {
        int         ch;
        bit         wr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_mem [256];
    int         model_rd, model_wr;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] prev_rd = '0, prev_wr = '0;
    logic [7:0] held [4];

    data_mem_responder dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rd_valid),
        .consumer_read_address  (rd_addr),
        .consumer_read_ready    (rd_ready),
        .consumer_read_data     (rd_data),
        .consumer_write_valid   (wr_valid),
        .consumer_write_address (wr_addr),
        .consumer_write_data    (wr_data),
        .consumer_write_ready   (wr_ready),
        .init_write_enable      (init_we),
        .init_address           (init_addr),
        .init_data              (init_dat),
        .busy                   (busy),
        .read_count             (read_count),
        .write_count            (write_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int model);
`ifdef DATA_MEM_RESPONDER_STATS_EN
        return model;
`else
        return 0 * model;
`endif
    endfunction

    task automatic sb_pop(input int ch, input bit wr, input logic [7:0] got);
        int pos = -1;
        for (int i = 0; i < sb.size(); i++)
            if (pos < 0 && sb[i].ch == ch && sb[i].wr == wr) pos = i;
        check($sformatf("sb_hit_ch%0d", ch), (pos >= 0), 1);
        if (pos >= 0) begin
            if (!wr) check($sformatf("rdata_ch%0d", ch), got, sb[pos].data);
            sb.delete(pos);
            if (wr) model_wr++; else model_rd++;
        end
    endtask

    // Scoreboard monitor: one pop per ready rise, and read data must hold while ready stays high.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (rd_ready[c] && !prev_rd[c]) begin
                sb_pop(c, 1'b0, rd_data[c*8 +: 8]);
                held[c] = rd_data[c*8 +: 8];
            end else if (rd_ready[c]) begin
                check($sformatf("hold_ch%0d", c), rd_data[c*8 +: 8], held[c]);
            end
            if (wr_ready[c] && !prev_wr[c]) sb_pop(c, 1'b1, 8'h00);
        end
        prev_rd = rd_ready;
        prev_wr = wr_ready;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        model_rd = 0;
        model_wr = 0;
        @(negedge clk);
    endtask

    task automatic init_write(input logic [7:0] a, input logic [7:0] d);
        init_we      = 1'b1;
        init_addr    = a;
        init_dat     = d;
        model_mem[a] = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // Raise a request at a negedge, wait (bounded) for its ready, check the edge count, then release.
    task automatic access(input int ch, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                          input int exp_edges, input string tag);
        int n   = 0;
        bit rdy = 1'b0;
        if (wr) begin
            wr_addr[ch*8 +: 8] = addr;
            wr_data[ch*8 +: 8] = wd;
            model_mem[addr]    = wd;
            sb.push_back('{ch, 1'b1, wd});
            wr_valid[ch] = 1'b1;
        end else begin
            rd_addr[ch*8 +: 8] = addr;
            sb.push_back('{ch, 1'b0, model_mem[addr]});
            rd_valid[ch] = 1'b1;
        end
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
            rdy = wr ? wr_ready[ch] : rd_ready[ch];
        end
        check({tag, "_edges"}, n - 1, exp_edges);
        check({tag, "_busy"}, busy, 1);
        if (wr) wr_valid[ch] = 1'b0; else rd_valid[ch] = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, wr ? wr_ready[ch] : rd_ready[ch], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        rd_valid = '0; wr_valid = '0;
        rd_addr  = '0; wr_addr  = '0; wr_data = '0;
        init_we  = 1'b0; init_addr = '0; init_dat = '0;
        model_rd = 0; model_wr = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_rd_ready", rd_ready, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rcount", read_count, 0);
        check("rst_wcount", write_count, 0);

        init_write(8'h10, 8'hA5);
        init_write(8'h11, 8'hC1);
        init_write(8'h12, 8'hC2);
        init_write(8'h13, 8'hC3);
        init_write(8'h30, 8'h5A);

        // Single read after preload.
        access(0, 1'b0, 8'h10, 8'h00, 2, "t1");

        // Write on ch2, then read it back on ch1.
        access(2, 1'b1, 8'h20, 8'h3C, 2, "t2w");
        access(1, 1'b0, 8'h20, 8'h00, 2, "t2r");
        check("t2_rcount", read_count, exp_cnt(model_rd));
        check("t2_wcount", write_count, exp_cnt(model_wr));

        // Reset returns the pointer to 0 and clears counters but keeps RAM.
        do_reset();
        check("t3_rcount_rst", read_count, 0);

        // All four channels on one edge: grants 0,1,2,3 on consecutive edges.
        fork
            access(0, 1'b0, 8'h10, 8'h00, 2, "t3c0");
            access(1, 1'b0, 8'h11, 8'h00, 3, "t3c1");
            access(2, 1'b0, 8'h12, 8'h00, 4, "t3c2");
            access(3, 1'b0, 8'h20, 8'h00, 5, "t3c3");
        join
        check("t3_busy_end", busy, 0);

        // Grant ch2 to park the pointer at 3; ch3 must then beat ch0.
        access(2, 1'b0, 8'h13, 8'h00, 2, "t4pre");
        fork
            access(0, 1'b0, 8'h12, 8'h00, 3, "t4c0");
            access(3, 1'b0, 8'h11, 8'h00, 2, "t4c3");
        join

        // Init strobe held 3 cycles blocks ch0's grant.
        fork
            access(0, 1'b0, 8'h10, 8'h00, 5, "t5");
            begin
                init_we   = 1'b1;
                init_addr = 8'h40;
                init_dat  = 8'h77;
                model_mem[8'h40] = 8'h77;
                repeat (3) @(negedge clk);
                init_we = 1'b0;
            end
        join
        access(1, 1'b0, 8'h40, 8'h00, 2, "t5rd");
        check("t5_rcount", read_count, exp_cnt(model_rd));

        // Reset during ch1 WAIT: the access is abandoned, RAM keeps its value.
        rd_addr[15:8] = 8'h30;
        rd_valid[1]   = 1'b1;
        @(negedge clk);
        reset       = 1'b1;
        rd_valid[1] = 1'b0;
        @(negedge clk);
        check("t6_busy_rst", busy, 0);
        check("t6_ready_rst", rd_ready, 0);
        reset    = 1'b0;
        model_rd = 0;
        model_wr = 0;
        repeat (5) @(negedge clk);
        check("t6_no_ready", rd_ready[1], 0);
        check("t6_rcount", read_count, 0);
        check("t6_wcount", write_count, 0);
        access(1, 1'b0, 8'h30, 8'h00, 2, "t6rd");
        check("t6_rcount2", read_count, exp_cnt(model_rd));

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
